// File: rtl/mvm_job_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mvm_job_ctrl
// Purpose  : Job sequencer between a host stream and one matrix-vector engine.
//            Each accepted command may load a new KxK matrix (row-major),
//            then buffers a K-element vector, streams it to the engine,
//            issues start and captures the K results into an output FIFO
//            that the host drains with valid/ready. Draining job n overlaps
//            with loading job n+1.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            cmd_valid/ready/mat   - job request; cmd_mat=1 carries a matrix
//            in_valid/ready/data   - matrix or vector words (B bits, signed)
//            out_valid/ready/data  - result words (2B bits), out_last on y[K-1]
//            busy, err             - not-idle flag, sticky protocol error
//            mvm_load_matrix/vector, mvm_start, mvm_data_in - engine controls
//            mvm_done, mvm_data_out                        - engine responses
// Revision : 1.0 - initial release
// ============================================================================
module mvm_job_ctrl #(
  parameter int K        = 32,
  parameter int B        = 8,
  parameter int LOAD_LAT = 1,
  parameter int OUT_LAT  = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic           cmd_mat,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [B-1:0]   in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*B-1:0] out_data,
  output logic           out_last,
  output logic           busy,
  output logic           err,
  output logic           mvm_load_matrix,
  output logic           mvm_load_vector,
  output logic           mvm_start,
  output logic [B-1:0]   mvm_data_in,
  input  logic           mvm_done,
  input  logic [2*B-1:0] mvm_data_out
);

  localparam int CNT_W = $clog2(K*K + K + LOAD_LAT + OUT_LAT);
  localparam int PTR_W = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    M_PULSE  = 4'd1,
    M_WAIT   = 4'd2,
    M_STREAM = 4'd3,
    V_FILL   = 4'd4,
    V_PULSE  = 4'd5,
    V_WAIT   = 4'd6,
    V_STREAM = 4'd7,
    S_WAIT   = 4'd8,
    CALC     = 4'd9,
    CAPTURE  = 4'd10
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               load_m_q, load_m_d;
  logic               load_v_q, load_v_d;
  logic               start_q, start_d;
  logic [B-1:0]       data_in_q, data_in_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               vbuf_we, obuf_we, obuf_rd;

  logic [B-1:0]       vbuf_q [K];
  logic [2*B-1:0]     obuf_q [K];

  assign obuf_rd = (count_q != '0) && out_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    load_m_d  = 1'b0;
    load_v_d  = 1'b0;
    start_d   = 1'b0;
    data_in_d = '0;
    vbuf_we   = 1'b0;
    obuf_we   = 1'b0;
    cmd_ready = 1'b0;
    in_ready  = 1'b0;

    // A completion pulse is only meaningful while waiting for one.
    if (mvm_done && (state_q != CALC)) err_d = 1'b1;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        cnt_d     = '0;
        if (cmd_valid) state_d = cmd_mat ? M_PULSE : V_FILL;
      end
      M_PULSE: begin
        load_m_d = 1'b1;
        cnt_d    = '0;
        state_d  = (LOAD_LAT > 1) ? M_WAIT : M_STREAM;
      end
      M_WAIT: begin
        if (cnt_q == CNT_W'(LOAD_LAT - 2)) begin
          cnt_d   = '0;
          state_d = M_STREAM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      M_STREAM: begin
        // The engine counts beats on its own, so a missing word still
        // consumes a beat (driven as 0) to keep both sides aligned.
        in_ready = 1'b1;
        if (in_valid) data_in_d = in_data;
        else          err_d     = 1'b1;
        if (cnt_q == CNT_W'(K*K - 1)) begin
          cnt_d   = '0;
          state_d = V_FILL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      V_FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          vbuf_we = 1'b1;
          if (cnt_q == CNT_W'(K - 1)) begin
            cnt_d   = '0;
            state_d = V_PULSE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      V_PULSE: begin
        load_v_d = 1'b1;
        cnt_d    = '0;
        state_d  = (LOAD_LAT > 1) ? V_WAIT : V_STREAM;
      end
      V_WAIT: begin
        if (cnt_q == CNT_W'(LOAD_LAT - 2)) begin
          cnt_d   = '0;
          state_d = V_STREAM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      V_STREAM: begin
        data_in_d = vbuf_q[cnt_q[PTR_W-1:0]];
        if (cnt_q == CNT_W'(K - 1)) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        // Starting only on an empty FIFO guarantees the K captures fit.
        if (count_q == '0) begin
          start_d = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        cnt_d = '0;
        if (mvm_done) state_d = CAPTURE;
      end
      CAPTURE: begin
        // cnt runs through OUT_LAT-1 wait cycles, then K write cycles.
        if (cnt_q >= CNT_W'(OUT_LAT - 1)) obuf_we = 1'b1;
        if (cnt_q == CNT_W'(OUT_LAT - 1 + K - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (obuf_we) wr_ptr_d = (wr_ptr_q == PTR_W'(K - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (obuf_rd) rd_ptr_d = (rd_ptr_q == PTR_W'(K - 1)) ? '0 : rd_ptr_q + 1'b1;
    if (obuf_we && !obuf_rd)      count_d = count_q + 1'b1;
    else if (!obuf_we && obuf_rd) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      load_m_q  <= 1'b0;
      load_v_q  <= 1'b0;
      start_q   <= 1'b0;
      data_in_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < K; i++) begin
        vbuf_q[i] <= '0;
        obuf_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      load_m_q  <= load_m_d;
      load_v_q  <= load_v_d;
      start_q   <= start_d;
      data_in_q <= data_in_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      if (vbuf_we) vbuf_q[cnt_q[PTR_W-1:0]] <= in_data;
      if (obuf_we) obuf_q[wr_ptr_q]         <= mvm_data_out;
    end
  end

  assign busy            = (state_q != IDLE);
  assign err             = err_q;
  assign mvm_load_matrix = load_m_q;
  assign mvm_load_vector = load_v_q;
  assign mvm_start       = start_q;
  assign mvm_data_in     = data_in_q;
  assign out_valid       = (count_q != '0);
  assign out_data        = obuf_q[rd_ptr_q];
  assign out_last        = (count_q != '0) && (rd_ptr_q == PTR_W'(K - 1));

endmodule
`default_nettype wire

// File: doc/mvm_job_ctrl.md
Name: mvm_job_ctrl

Overview:
- Job sequencer between a host stream interface and one mvm_K_P_B_G engine.
- Per accepted command: optionally loads a new K×K matrix, buffers and loads a K-element vector, issues start, then captures the K results into an output buffer drained with valid/ready backpressure.
- Draining results of job n overlaps with loading job n+1.

Parameters:
- K, 32, matrix dimension / vector length.
- B, 8, input word width; results are 2*B.
- LOAD_LAT, 1, cycles from mvm_load_* pulse to the first word driven on mvm_data_in (≥1).
- OUT_LAT, 2, cycles from the mvm_done pulse to the first result word on mvm_data_out (≥1).

Ports:
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- cmd_valid  in  1  job request
- cmd_ready  out  1  controller accepts command (IDLE only)
- cmd_mat  in  1  1 = job carries a new matrix before its vector
- in_valid  in  1  input word valid
- in_ready  out  1  controller accepts input word
- in_data  in  B  signed matrix (row-major) or vector word
- out_valid  out  1  result word valid
- out_ready  in  1  consumer accepts result
- out_data  out  2B  result word y[i], i ascending
- out_last  out  1  high with y[K-1]
- busy  out  1  state != IDLE
- err  out  1  sticky protocol error, cleared only by reset
- mvm_load_matrix, mvm_load_vector, mvm_start  out  1 each  single-cycle pulses to the engine
- mvm_data_in  out  B  engine data input
- mvm_done  in  1  engine completion pulse
- mvm_data_out  in  2B  engine result stream

Behaviour:
- Reset:
  - All outputs 0 and state IDLE.
  - Output buffer count 0; vector buffer emptied; err cleared.
  - Reset mid-job aborts immediately; the engine shares the same reset.
- Handshakes: a transfer occurs on any cycle with valid && ready.
- FSM states: IDLE, M_PULSE, M_WAIT, M_STREAM, V_FILL, V_PULSE, V_WAIT, V_STREAM, S_WAIT, CALC, CAPTURE.
- IDLE:
  - cmd_ready = 1.
  - On a cmd transfer, go to M_PULSE if cmd_mat = 1, else V_FILL.
- M_PULSE: mvm_load_matrix = 1 for one cycle.
- M_WAIT: holds LOAD_LAT-1 cycles (skipped if LOAD_LAT = 1).
- M_STREAM:
  - Exactly K*K consecutive beats; in_ready = 1; mvm_data_in = in_data.
  - A beat with in_valid = 0 sets err and drives 0.
  - The beat counter advances regardless, so the engine stays aligned.
  - Then go to V_FILL.
- V_FILL:
  - Accepts K words into a K×B buffer at idx 0..K-1; bubbles allowed.
  - in_ready = 1 until the K-th transfer.
- V_PULSE / V_WAIT: mvm_load_vector pulse, then LOAD_LAT-1 idle cycles.
- V_STREAM: drives buffer[0..K-1] on mvm_data_in on K consecutive cycles; in_ready = 0.
- S_WAIT:
  - Waits until the output buffer count == 0, then pulses mvm_start and goes to CALC.
  - If the buffer is already empty, the pulse occurs on the first S_WAIT cycle.
- CALC:
  - Waits for mvm_done, then goes to CAPTURE.
  - No timeout.
- CAPTURE:
  - After OUT_LAT-1 further cycles, writes mvm_data_out into the output buffer on K consecutive cycles.
  - Returns to IDLE after the K-th write.
- Output buffer:
  - K×2B FIFO, pointer wrap at K.
  - out_valid = count != 0; out_data is the registered head.
  - out_last is high when the head index == K-1.
  - Simultaneous write and read keeps count unchanged.
  - Overflow cannot occur, because start requires count == 0.
- mvm_done outside CALC is ignored and sets err.
- in_ready = 0 in all states other than M_STREAM and V_FILL.
- in_data arriving while in_ready = 0 is not consumed.
- All mvm_* outputs are registered.
- mvm_data_in = 0 outside the stream states.
- Throughput: with no bubbles, a cmd_mat = 1 job costs 2+LOAD_LAT*2+K*K+2K cycles plus engine time before start.

Test Plan:
- K=4, LOAD_LAT=1:
  - Stimulus: cmd_mat=1, matrix 1..16, vector {1,1,1,1}, out_ready=1.
  - mvm_load_matrix precedes the 16 data cycles by exactly 1.
  - out_data = 10, 26, 42, 58, with out_last on 58.
  - err = 0.
- cmd_mat=0 reusing the prior matrix, vector {1,0,0,-1} sent with a 2-cycle in_valid bubble:
  - Outputs are -3, -3, -3, -3.
  - The V_STREAM words are contiguous despite the bubble.
- Backpressure: out_ready=0 after the first result of job A, while job B is loaded:
  - mvm_start for job B is held until all 4 results of job A have drained.
  - No results are lost or duplicated.
- in_valid=0 on matrix beat 7:
  - err rises and stays high.
  - Exactly 16 matrix beats are still issued.
  - The FSM returns to IDLE after the job.
- mvm_done pulsed in IDLE:
  - err = 1.
  - No result is captured; cmd_ready stays 1.
- reset asserted mid-M_STREAM:
  - Next cycle: IDLE, cmd_ready=1, out_valid=0, err=0.
  - A following full job produces correct results.
